// File: rtl/alu_n.sv
// alu_n: registered N-bit ALU with start/done handshake, zero/carry/overflow
// flags and signed set-less-than. Defining ALU_MULT_EN compiles in an
// iterative shift-add multiplier (op 1000) that holds busy for WIDTH cycles.
// Without ALU_MULT_EN, op 1000 behaves like any undefined code.
module alu_n #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam int         CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [WIDTH:0]     hi_add_s;
  logic [2*WIDTH:0]   step_s;
`endif

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;

  // Single-cycle datapath: A+B and A+~B+1 share the sign/overflow logic used by SLT.
  always_comb begin
    sum_s     = {1'b0, data_in_0} + {1'b0, data_in_1};
    diff_s    = {1'b0, data_in_0} + {1'b0, ~data_in_1} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf_s = (data_in_0[WIDTH-1] == data_in_1[WIDTH-1]) &&
                (sum_s[WIDTH-1] != data_in_0[WIDTH-1]);
    sub_ovf_s = (data_in_0[WIDTH-1] != data_in_1[WIDTH-1]) &&
                (diff_s[WIDTH-1] != data_in_0[WIDTH-1]);
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (alu_control)
      OP_AND: alu_res_s = data_in_0 & data_in_1;
      OP_OR:  alu_res_s = data_in_0 | data_in_1;
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = add_ovf_s;
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = sub_ovf_s;
      end
      // Sign of A-B corrected by overflow gives the true signed comparison.
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
      OP_NOR: alu_res_s = ~(data_in_0 | data_in_1);
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

`ifdef ALU_MULT_EN
  // One shift-add step: conditionally add multiplicand into the upper half, then shift right.
  always_comb begin
    hi_add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    if (acc_q[0]) begin
      step_s = {hi_add_s, acc_q[WIDTH-1:0]};
    end else begin
      step_s = {1'b0, acc_q};
    end
  end
`endif

  // Next-state logic: outputs hold until an operation completes.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifdef ALU_MULT_EN
    state_d     = state_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    result_hi_d = result_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (alu_control == OP_MULT)) begin
          mcand_d = data_in_0;
          acc_d   = {{WIDTH{1'b0}}, data_in_1};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_MUL;
        end else if (start) begin
          result_d    = alu_res_s;
          result_hi_d = {WIDTH{1'b0}};
          zero_d      = (alu_res_s == {WIDTH{1'b0}});
          carry_d     = alu_c_s;
          ovf_d       = alu_v_s;
          done_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = step_s[2*WIDTH:1];
        if (cnt_q == CNT_LAST) begin
          result_d    = step_s[WIDTH:1];
          result_hi_d = step_s[2*WIDTH:WIDTH+1];
          zero_d      = (step_s[WIDTH:1] == {WIDTH{1'b0}});
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
`else
    if (start) begin
      result_d = alu_res_s;
      zero_d   = (alu_res_s == {WIDTH{1'b0}});
      carry_d  = alu_c_s;
      ovf_d    = alu_v_s;
      done_d   = 1'b1;
    end else begin
      done_d = 1'b0;
    end
`endif
  end

  // State and output registers; reset clears everything except zero, which tracks result==0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MULT_EN
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
`endif
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
`ifdef ALU_MULT_EN
      state_q     <= state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      result_hi_q <= result_hi_d;
`endif
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
`ifdef ALU_MULT_EN
  assign busy      = busy_q;
  assign result_hi = result_hi_q;
`else
  assign busy      = 1'b0;
  assign result_hi = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu_n.sv
// Directed testbench for alu_n at WIDTH=8: vector table for single-cycle ops,
// hand-written sequences for MULT (or its undefined-op behaviour) and reset.
module tb_alu_n;
  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] data_in_0;
  logic [W-1:0] data_in_1;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  alu_n #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] r, input logic c, input logic v, input logic z);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.r = r; t.c = c; t.v = v; t.z = z;
    return t;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    start       = 1'b1;
    alu_control = op;
    data_in_0   = a;
    data_in_1   = b;
  endtask

  initial begin
    int n;
    int dn;
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    alu_control = 4'b0000;
    data_in_0   = 8'h00;
    data_in_1   = 8'h00;

    //              op       A      B      res    c     v     z
    vecs.push_back(mk(4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0110, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0011, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1));
`ifndef ALU_MULT_EN
    vecs.push_back(mk(4'b1000, 8'h03, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1));
`endif

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset result", {8'h00, result}, 16'h0000);
    check("reset result_hi", {8'h00, result_hi}, 16'h0000);
    check("reset zero", {15'h0, zero}, 16'h0001);
    check("reset carry", {15'h0, carry_out}, 16'h0000);
    check("reset overflow", {15'h0, overflow}, 16'h0000);
    check("reset busy", {15'h0, busy}, 16'h0000);
    check("reset done", {15'h0, done}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back single-cycle ops: done every cycle
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d result", i), {8'h00, result}, {8'h00, vecs[i].r});
      check($sformatf("vec%0d carry", i), {15'h0, carry_out}, {15'h0, vecs[i].c});
      check($sformatf("vec%0d overflow", i), {15'h0, overflow}, {15'h0, vecs[i].v});
      check($sformatf("vec%0d zero", i), {15'h0, zero}, {15'h0, vecs[i].z});
      check($sformatf("vec%0d done", i), {15'h0, done}, 16'h0001);
      check($sformatf("vec%0d busy", i), {15'h0, busy}, 16'h0000);
      check($sformatf("vec%0d result_hi", i), {8'h00, result_hi}, 16'h0000);
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("idle done low", {15'h0, done}, 16'h0000);
    check("idle result held", {8'h00, result}, {8'h00, vecs[vecs.size()-1].r});

`ifdef ALU_MULT_EN
    // MULT 0xFF x 0xFF with ignored start pulses while busy
    issue(4'b1000, 8'hFF, 8'hFF);
    @(posedge clock);
    #1;
    check("mult busy after start", {15'h0, busy}, 16'h0001);
    check("mult no early done", {15'h0, done}, 16'h0000);
    n = 1;
    dn = 0;
    for (int k = 0; k < 40 && dn == 0; k++) begin
      @(negedge clock);
      start       = k[0];
      alu_control = 4'b0010;
      data_in_0   = 8'h11;
      data_in_1   = 8'h22;
      @(posedge clock);
      #1;
      if (done) dn = 1;
      else if (busy) n++;
    end
    check("mult done seen", dn[15:0], 16'h0001);
    check("mult busy cycles", n[15:0], 16'h0008);
    check("mult result lo", {8'h00, result}, 16'h0001);
    check("mult result hi", {8'h00, result_hi}, 16'h00FE);
    check("mult busy at done", {15'h0, busy}, 16'h0000);
    check("mult zero", {15'h0, zero}, 16'h0000);
    check("mult carry", {15'h0, carry_out}, 16'h0000);
    check("mult overflow", {15'h0, overflow}, 16'h0000);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("mult done one pulse", {15'h0, done}, 16'h0000);
    check("mult result held", {8'h00, result}, 16'h0001);

    // MULT 0x0D x 0x0B = 0x008F, then 0x00 x 0x55 = 0 (zero flag)
    issue(4'b1000, 8'h0D, 8'h0B);
    @(negedge clock);
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 40 && dn == 0; k++) begin
      @(posedge clock);
      #1;
      if (done) dn = 1;
    end
    check("mult2 done seen", dn[15:0], 16'h0001);
    check("mult2 product", {result_hi, result}, 16'h008F);
    issue(4'b1000, 8'h00, 8'h55);
    @(negedge clock);
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 40 && dn == 0; k++) begin
      @(posedge clock);
      #1;
      if (done) dn = 1;
    end
    check("mult3 product", {result_hi, result}, 16'h0000);
    check("mult3 zero", {15'h0, zero}, 16'h0001);

    // Reset during iteration 4 aborts without done
    issue(4'b0010, 8'h01, 8'h02);
    issue(4'b1000, 8'hFF, 8'hFF);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abort busy before reset", {15'h0, busy}, 16'h0001);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort busy", {15'h0, busy}, 16'h0000);
    check("abort result", {result_hi, result}, 16'h0000);
    check("abort zero", {15'h0, zero}, 16'h0001);
    check("abort done", {15'h0, done}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (done || busy) dn++;
    end
    check("abort no done later", dn[15:0], 16'h0000);
`endif

    // ADD completes in one cycle after the MULT section / reset
    issue(4'b0010, 8'h02, 8'h03);
    @(posedge clock);
    #1;
    check("post add result", {8'h00, result}, 16'h0005);
    check("post add done", {15'h0, done}, 16'h0001);
    check("post add busy", {15'h0, busy}, 16'h0000);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("post add done drop", {15'h0, done}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
